cp0_ctrl: RTL and testbench

Clocked, parametrised coprocessor-0 controller for the Minisys-1A write-back stage. It holds Status, Cause, EPC, Count and Compare, and prioritises synchronous exceptions over `NUM_IRQ` maskable level interrupts plus a built-in timer. It issues a one-cycle PC redirect to the handler on exception entry, or to EPC on `eret`. Unlike the earlier combinational CP0, all state changes happen on the clock edge and nested entry is guarded by Status.EXL.

---
 rtl/cp0_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cp0_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller for the Minisys-1A write-back stage.
// Holds Status, Cause, EPC, Count and Compare. Synchronous exceptions take
// priority over ERET, and ERET takes priority over maskable interrupts.
// Exception entry and ERET both redirect the PC through a registered
// one-cycle pulse.
module cp0_ctrl #(
  parameter int unsigned NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_F500,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exc_syscall,
  input  logic               exc_div_zero,
  input  logic               exc_break,
  input  logic               exc_reserved,
  input  logic               exc_overflow,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        pc,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [4:0]         rd,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               int_pending
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Status fields
  logic               ie, ie_n;
  logic               exl, exl_n;
  logic [1:0]         ksu, ksu_n;
  logic [NUM_IRQ-1:0] im, im_n;
  // Cause fields
  logic [4:0]         exc_code, exc_code_n;
  logic [NUM_IRQ-1:0] ip, ip_n;
  logic               ti, ti_n;
  // Remaining registers and the ERET shadows
  logic [31:0]        epc, epc_n;
  logic [31:0]        count, count_n;
  logic [31:0]        compare, compare_n;
  logic               prev_ie, prev_ie_n;
  logic [1:0]         prev_ksu, prev_ksu_n;
  // Output registers
  logic [31:0]        rdata_n;
  logic               redirect_n;
  logic [31:0]        redirect_pc_n;

  logic               sync_exc;
  logic               irq_visible;
  logic               take_int;
  logic               entry;
  logic               eret_fire;
  logic               wr_en;
  logic [4:0]         code;
  logic [31:0]        status_val;
  logic [31:0]        cause_val;
  logic [31:0]        read_val;

  // Event decode: exception code priority and entry/ERET qualification
  always_comb begin
    sync_exc    = exc_syscall | exc_div_zero | exc_break | exc_reserved | exc_overflow;
    irq_visible = ie & ~exl & (|(ip & im));
    take_int    = irq_visible & ~sync_exc & ~eret;
    entry       = sync_exc | take_int;
    eret_fire   = eret & ~sync_exc;
    wr_en       = mtc0 & ~entry & ~eret_fire;
    if (exc_syscall)       code = 5'd8;
    else if (exc_div_zero) code = 5'd7;
    else if (exc_break)    code = 5'd9;
    else if (exc_reserved) code = 5'd10;
    else if (exc_overflow) code = 5'd12;
    else                   code = 5'd0;
  end

  assign int_pending = irq_visible;

  // Register read view: unimplemented bits and indices read as zero
  always_comb begin
    status_val              = '0;
    status_val[0]           = ie;
    status_val[1]           = exl;
    status_val[4:3]         = ksu;
    status_val[8+:NUM_IRQ]  = im;
    cause_val               = '0;
    cause_val[6:2]          = exc_code;
    cause_val[8+:NUM_IRQ]   = ip;
    cause_val[30]           = ti;
    case (rd)
      REG_COUNT:   read_val = count;
      REG_COMPARE: read_val = compare;
      REG_STATUS:  read_val = status_val;
      REG_CAUSE:   read_val = cause_val;
      REG_EPC:     read_val = epc;
      default:     read_val = '0;
    endcase
  end

  // Next-state computation for all CP0 state and registered outputs
  always_comb begin
    ie_n          = ie;
    exl_n         = exl;
    ksu_n         = ksu;
    im_n          = im;
    exc_code_n    = exc_code;
    epc_n         = epc;
    compare_n     = compare;
    prev_ie_n     = prev_ie;
    prev_ksu_n    = prev_ksu;
    count_n       = count + 32'd1;
    rdata_n       = mfc0 ? read_val : rdata;
    redirect_n    = entry | eret_fire;
    redirect_pc_n = redirect_pc;

    // IP samples the lines every cycle; the timer shares the top line
    ip_n              = irq;
    ip_n[NUM_IRQ-1]   = irq[NUM_IRQ-1] | ti;

    if (entry) begin
      exc_code_n    = code;
      if (!exl) begin
        epc_n      = pc;
        prev_ie_n  = ie;
        prev_ksu_n = ksu;
      end
      ie_n          = 1'b0;
      ksu_n         = 2'b00;
      exl_n         = 1'b1;
      redirect_pc_n = HANDLER_ADDR;
    end else if (eret_fire) begin
      ie_n          = prev_ie;
      ksu_n         = prev_ksu;
      exl_n         = 1'b0;
      redirect_pc_n = epc;
    end else if (wr_en) begin
      case (rd)
        REG_COUNT:   count_n   = wdata;
        REG_COMPARE: compare_n = wdata;
        REG_STATUS: begin
          ie_n  = wdata[0];
          exl_n = wdata[1];
          ksu_n = wdata[4:3];
          im_n  = wdata[8+:NUM_IRQ];
        end
        REG_CAUSE:   exc_code_n = wdata[6:2];
        REG_EPC:     epc_n      = wdata;
        default: ;
      endcase
    end

    // TI is sticky; it rises with the edge that brings Count onto Compare
    if (wr_en && rd == REG_COMPARE) ti_n = 1'b0;
    else                            ti_n = ti | (count_n == compare);
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ie          <= STATUS_RESET[0];
      exl         <= STATUS_RESET[1];
      ksu         <= STATUS_RESET[4:3];
      im          <= STATUS_RESET[8+:NUM_IRQ];
      exc_code    <= '0;
      ip          <= '0;
      ti          <= 1'b0;
      epc         <= '0;
      count       <= '0;
      compare     <= '0;
      prev_ie     <= 1'b0;
      prev_ksu    <= '0;
      rdata       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      ie          <= ie_n;
      exl         <= exl_n;
      ksu         <= ksu_n;
      im          <= im_n;
      exc_code    <= exc_code_n;
      ip          <= ip_n;
      ti          <= ti_n;
      epc         <= epc_n;
      count       <= count_n;
      compare     <= compare_n;
      prev_ie     <= prev_ie_n;
      prev_ksu    <= prev_ksu_n;
      rdata       <= rdata_n;
      redirect    <= redirect_n;
      redirect_pc <= redirect_pc_n;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl with NUM_IRQ=6.
module tb_cp0_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        exc_syscall, exc_div_zero, exc_break, exc_reserved, exc_overflow;
  logic        eret;
  logic [5:0]  irq;
  logic [31:0] pc;
  logic        mfc0, mtc0;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        int_pending;

  int checks = 0;
  int errors = 0;

  cp0_ctrl #(
    .NUM_IRQ(6),
    .HANDLER_ADDR(32'h0000_F500),
    .STATUS_RESET(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .exc_syscall(exc_syscall),
    .exc_div_zero(exc_div_zero),
    .exc_break(exc_break),
    .exc_reserved(exc_reserved),
    .exc_overflow(exc_overflow),
    .eret(eret),
    .irq(irq),
    .pc(pc),
    .mfc0(mfc0),
    .mtc0(mtc0),
    .rd(rd),
    .wdata(wdata),
    .rdata(rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .int_pending(int_pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_mtc0(input logic [4:0] r, input logic [31:0] d);
    mtc0 = 1'b1; rd = r; wdata = d;
    step();
    mtc0 = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] r, input logic [31:0] expected);
    mfc0 = 1'b1; rd = r;
    step();
    mfc0 = 1'b0;
    check(tag, rdata, expected);
  endtask

  initial begin
    reset = 1'b1;
    exc_syscall = 0; exc_div_zero = 0; exc_break = 0; exc_reserved = 0; exc_overflow = 0;
    eret = 0; irq = '0; pc = '0; mfc0 = 0; mtc0 = 0; rd = '0; wdata = '0;

    // Reset state
    step(); step();
    check("rst_rdata", rdata, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_int_pending", {31'b0, int_pending}, 32'h0);
    reset = 1'b0;
    do_read("rst_status", 5'd12, 32'h0);

    // Interrupt entry through irq[0]
    do_mtc0(5'd12, 32'h0000_0101);
    irq = 6'b000001; pc = 32'h100;
    step();
    check("irq_pending", {31'b0, int_pending}, 32'h1);
    check("irq_no_redirect_yet", {31'b0, redirect}, 32'h0);
    step();
    check("irq_redirect", {31'b0, redirect}, 32'h1);
    check("irq_redirect_pc", redirect_pc, 32'h0000_F500);
    check("irq_pending_exl", {31'b0, int_pending}, 32'h0);
    irq = '0;
    do_read("irq_epc", 5'd14, 32'h100);
    check("irq_redirect_pulse", {31'b0, redirect}, 32'h0);
    do_read("irq_status", 5'd12, 32'h0000_0102);
    do_read("irq_cause", 5'd13, 32'h0);

    // ERET back to EPC
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("eret_redirect", {31'b0, redirect}, 32'h1);
    check("eret_redirect_pc", redirect_pc, 32'h100);
    do_read("eret_status", 5'd12, 32'h0000_0101);
    check("eret_redirect_pulse", {31'b0, redirect}, 32'h0);

    // Priority among simultaneous sync flags, then nested entry
    exc_syscall = 1'b1; exc_overflow = 1'b1; pc = 32'h200;
    step();
    exc_syscall = 1'b0; exc_overflow = 1'b0;
    check("sys_redirect", {31'b0, redirect}, 32'h1);
    check("sys_redirect_pc", redirect_pc, 32'h0000_F500);
    do_read("sys_cause", 5'd13, 32'h20);
    do_read("sys_epc", 5'd14, 32'h200);
    exc_break = 1'b1; pc = 32'h300;
    step();
    exc_break = 1'b0;
    check("nest_redirect", {31'b0, redirect}, 32'h1);
    do_read("nest_cause", 5'd13, 32'h24);
    do_read("nest_epc", 5'd14, 32'h200);
    do_read("nest_status", 5'd12, 32'h0000_0102);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("nest_eret_pc", redirect_pc, 32'h200);
    do_read("nest_eret_status", 5'd12, 32'h0000_0101);

    // Masked interrupt, then unmask IM[10]
    irq = 6'b000100; pc = 32'h400;
    for (int i = 0; i < 20; i++) begin
      step();
      check("mask_redirect", {31'b0, redirect}, 32'h0);
      check("mask_pending", {31'b0, int_pending}, 32'h0);
    end
    do_mtc0(5'd12, 32'h0000_0501);
    check("unmask_pending", {31'b0, int_pending}, 32'h1);
    check("unmask_no_redirect_yet", {31'b0, redirect}, 32'h0);
    step();
    check("unmask_redirect", {31'b0, redirect}, 32'h1);
    irq = '0;
    do_read("unmask_epc", 5'd14, 32'h400);
    do_read("unmask_cause", 5'd13, 32'h0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("unmask_eret_pc", redirect_pc, 32'h400);
    do_read("unmask_eret_status", 5'd12, 32'h0000_0501);
    do_mtc0(5'd12, 32'h0);

    // Timer: Compare=10, Count restarted at 0
    do_mtc0(5'd11, 32'd10);
    do_mtc0(5'd9, 32'd0);
    do_read("count_zero", 5'd9, 32'd0);
    repeat (8) step();
    do_read("ti_at_count9", 5'd13, 32'h0);
    do_read("ti_at_count10", 5'd13, 32'h4000_0000);
    do_read("ip13_after_ti", 5'd13, 32'h4000_2000);
    check("timer_no_pending", {31'b0, int_pending}, 32'h0);
    mtc0 = 1'b1; mfc0 = 1'b1; rd = 5'd11; wdata = 32'hFFFF_0000;
    step();
    mtc0 = 1'b0; mfc0 = 1'b0;
    check("rw_same_cycle_old", rdata, 32'd10);
    do_read("ti_cleared", 5'd13, 32'h2000);
    do_read("ip13_cleared", 5'd13, 32'h0);

    // mtc0 EPC dropped by a simultaneous exception
    mtc0 = 1'b1; rd = 5'd14; wdata = 32'hABC; exc_overflow = 1'b1; pc = 32'h40;
    step();
    mtc0 = 1'b0; exc_overflow = 1'b0;
    check("drop_redirect", {31'b0, redirect}, 32'h1);
    do_read("drop_epc", 5'd14, 32'h40);
    do_read("ovf_cause", 5'd13, 32'h30);
    step();
    check("rdata_hold", rdata, 32'h30);

    // Reset asserted together with an exception
    exc_break = 1'b1; reset = 1'b1;
    step();
    exc_break = 1'b0; reset = 1'b0;
    check("midrst_redirect", {31'b0, redirect}, 32'h0);
    check("midrst_redirect_pc", redirect_pc, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    do_read("midrst_status", 5'd12, 32'h0);
    do_read("midrst_epc", 5'd14, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
